reg_bank_mem: RTL and testbench
===============================

// Module: reg_bank_mem
// PURPOSE
//  Daisy-chained bus peripheral on the 16-bit addr/wdata/rdata/rw/valid ring.
//  Exposes N_REGS registers of arbitrary width; each spans WORDS = ceil(REG_WIDTH/16) bus addresses.
//  Each register is either a probe (user->host, read-only) or an IO (host->user).
//  Access is atomic through a strobe register: probe snapshot on request, IO outputs committed on request.
// PARAMETERS
//  BASE_ADDR  0      first bus address owned (strobe register)
//  N_REGS     4      number of registers, >=1
//  REG_WIDTH  32     bits per register, 1..256
//  RO_MASK    0      N_REGS-bit mask; bit i=1 -> reg i is probe, 0 -> IO
//  IO_INIT    0      reset value of every IO shadow and io_o slice (REG_WIDTH bits)
// PORTS
//  clk        in   1                      clock, rising edge
//  rst_n      in   1                      async active-low reset
//  addr_i     in   16                     bus address in
//  wdata_i    in   16                     bus write data in
//  rdata_i    in   16                     bus read data in (upstream)
//  rw_i       in   1                      1=write, 0=read
//  valid_i    in   1                      bus transaction valid
//  addr_o     out  16                     registered addr_i
//  wdata_o    out  16                     registered wdata_i
//  rdata_o    out  16                     rdata_i, or this block's read data
//  rw_o       out  1                      registered rw_i
//  valid_o    out  1                      registered valid_i
//  probe_i    in   N_REGS*REG_WIDTH       user values; reg i at [i*REG_WIDTH +: REG_WIDTH]
//  io_o       out  N_REGS*REG_WIDTH       committed IO values (probe slices drive 0)
//  commit_o   out  1                      1-cycle pulse when io_o updates
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): bus outputs 0, strobe reg 0, probe snapshots 0,
//   IO shadows and io_o slices = IO_INIT, commit_o 0.
//  Bus pass-through: every cycle, the *_o outputs take the *_i values one cycle later (latency 1).
//   rdata_o is overridden only for valid reads that hit this block.
//  Address map, A = addr_i - BASE_ADDR:
//   A=0: strobe register.
//   A=1+i*WORDS+w: word w (w=0 least significant) of reg i.
//   Top address = BASE_ADDR+N_REGS*WORDS. Addresses outside the map pass through untouched.
//  Reads: rdata_o <= word w of the probe snapshot (probe reg) or of the IO shadow (IO reg).
//   Bits at or above REG_WIDTH read 0.
//   A strobe read returns the last written strobe value, bits [1:0] only, upper bits 0.
//  Writes to IO word: the shadow word is updated and io_o is unchanged. Bits above REG_WIDTH are dropped.
//  Writes to probe word: ignored. Packet still forwarded.
//  Write to strobe, same edge:
//   wdata[0]=1 -> all probe snapshots <= probe_i as sampled at that edge.
//   wdata[1]=1 -> all io_o IO slices <= shadow (pre-edge shadow value); commit_o=1 next cycle only.
//   Both bits set -> both actions on the same edge. wdata=0 -> stores value, no action.
//  Only one bus transaction per cycle; no host-side conflicts.
//  probe_i may change freely; only the snapshot edge matters.
//  Reset mid-sequence: partially written shadows are discarded (return to IO_INIT); no commit occurs.
//  Width: address comparisons done in 17 bits so BASE_ADDR+span never wraps. If the span exceeds 0xFFFF, elaborate error.
// TESTING  (BASE_ADDR=0x10, N_REGS=2, REG_WIDTH=24, RO_MASK=2'b10, IO_INIT=0; WORDS=2)
//  1. Reset: drive rst_n=0 mid-cycle -> all outputs 0 immediately.
//     Read 0x11 -> rdata_o=0x0000.
//  2. Pass-through: valid read 0x20, rdata_i=0xBEEF -> 1 cycle later addr_o=0x20, rdata_o=0xBEEF.
//  3. Staged IO write: write 0x11=0xCAFE, 0x12=0x12AB -> io_o[23:0] stays 0.
//     Read 0x12 -> 0x00AB.
//     Write 0x10=0x2 -> io_o[23:0]=0xABCAFE, commit_o high exactly 1 cycle.
//  4. Probe snapshot: probe_i[47:24]=0x123456.
//     Write 0x10=0x1, then change probe_i to 0.
//     Read 0x13 -> 0x3456, read 0x14 -> 0x0012.
//  5. Read-only guard: write 0x13=0xFFFF -> snapshot unchanged, io_o[47:24]=0.
//     Packet forwarded with wdata_o=0xFFFF.
//  6. Boundary: access 0x0F and 0x15 -> pass-through, no state change.
//     Strobe write 0x3 snapshots and commits in one cycle.

Source files
------------

// File: rtl/reg_bank_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reg_bank_mem                                               |
// | Purpose : Daisy-chained ring-bus register bank. Probe registers are  |
// |           snapshotted and IO registers committed atomically via a    |
// |           strobe register at BASE_ADDR.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module reg_bank_mem #(
  parameter int unsigned          BASE_ADDR = 0,
  parameter int unsigned          N_REGS    = 4,
  parameter int unsigned          REG_WIDTH = 32,
  parameter logic [N_REGS-1:0]    RO_MASK   = '0,
  parameter logic [REG_WIDTH-1:0] IO_INIT   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 addr_i,
  input  logic [15:0]                 wdata_i,
  input  logic [15:0]                 rdata_i,
  input  logic                        rw_i,
  input  logic                        valid_i,
  output logic [15:0]                 addr_o,
  output logic [15:0]                 wdata_o,
  output logic [15:0]                 rdata_o,
  output logic                        rw_o,
  output logic                        valid_o,
  input  logic [N_REGS*REG_WIDTH-1:0] probe_i,
  output logic [N_REGS*REG_WIDTH-1:0] io_o,
  output logic                        commit_o
);

  localparam int unsigned WORDS = (REG_WIDTH + 15) / 16;
  localparam int unsigned PADW  = WORDS * 16;
  localparam int unsigned SPAN  = N_REGS * WORDS;
  // Bits of the padded word storage that actually belong to the register.
  localparam logic [PADW-1:0] VMASK = PADW'({REG_WIDTH{1'b1}});

  if (BASE_ADDR + SPAN > 32'h0000_FFFF) begin : g_span_err
    $error("reg_bank_mem: BASE_ADDR + N_REGS*WORDS exceeds 0xFFFF");
  end
  if (N_REGS < 1 || REG_WIDTH < 1 || REG_WIDTH > 256) begin : g_param_err
    $error("reg_bank_mem: N_REGS must be >=1 and REG_WIDTH within 1..256");
  end

  // Address decode in 17 bits: addresses below BASE_ADDR wrap to a large
  // value and therefore fall outside the map.
  logic [16:0] rel;
  logic [16:0] widx;
  logic        in_map;
  logic        is_strobe;
  logic        wr_cyc;
  logic        rd_hit;
  logic        strobe_wr;

  assign rel       = {1'b0, addr_i} - 17'(BASE_ADDR);
  assign widx      = rel - 17'd1;
  assign in_map    = (rel <= 17'(SPAN));
  assign is_strobe = (rel == 17'd0);
  assign wr_cyc    = valid_i & rw_i;
  assign rd_hit    = valid_i & ~rw_i & in_map;
  assign strobe_wr = wr_cyc & is_strobe;

  logic [1:0]  strobe;
  logic [15:0] reg_rd [N_REGS];
  logic [15:0] rd_sel;

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    // Shadow (IO) or snapshot (probe) storage, padded to whole bus words.
    logic [PADW-1:0] data;
    logic [15:0]     rd_word;

    // Select the addressed word of this register; zero when not addressed.
    always_comb begin
      rd_word = '0;
      for (int w = 0; w < WORDS; w++) begin
        if (widx == 17'(i * WORDS + w)) rd_word = data[w*16 +: 16];
      end
    end
    assign reg_rd[i] = rd_word;

    if (RO_MASK[i]) begin : g_probe
      // Capture the user value when the host requests a snapshot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= '0;
        else if (strobe_wr && wdata_i[0])
          data <= PADW'(probe_i[i*REG_WIDTH +: REG_WIDTH]);
      end
      assign io_o[i*REG_WIDTH +: REG_WIDTH] = '0;
    end else begin : g_io
      logic [REG_WIDTH-1:0] io_q;
      logic                 unused_probe;
      assign unused_probe = ^probe_i[i*REG_WIDTH +: REG_WIDTH];

      // Stage host writes word by word; bits beyond REG_WIDTH never stick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= PADW'(IO_INIT);
        else if (wr_cyc) begin
          for (int w = 0; w < WORDS; w++) begin
            if (widx == 17'(i * WORDS + w))
              data[w*16 +: 16] <= wdata_i & VMASK[w*16 +: 16];
          end
        end
      end

      // Commit the staged shadow to the user-visible outputs on request.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) io_q <= IO_INIT;
        else if (strobe_wr && wdata_i[1]) io_q <= data[REG_WIDTH-1:0];
      end
      assign io_o[i*REG_WIDTH +: REG_WIDTH] = io_q;
    end
  end

  // Read data for a hit: strobe value or the single addressed register word.
  always_comb begin
    rd_sel = '0;
    if (is_strobe) rd_sel = {14'd0, strobe};
    else begin
      for (int i = 0; i < N_REGS; i++) rd_sel = rd_sel | reg_rd[i];
    end
  end

  // Strobe register remembers the last written action bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe <= 2'd0;
    else if (strobe_wr) strobe <= wdata_i[1:0];
  end

  // Forward the bus with one cycle of latency, inserting read data on hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_o   <= '0;
      wdata_o  <= '0;
      rdata_o  <= '0;
      rw_o     <= 1'b0;
      valid_o  <= 1'b0;
      commit_o <= 1'b0;
    end else begin
      addr_o   <= addr_i;
      wdata_o  <= wdata_i;
      rdata_o  <= rd_hit ? rd_sel : rdata_i;
      rw_o     <= rw_i;
      valid_o  <= valid_i;
      commit_o <= strobe_wr & wdata_i[1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_reg_bank_mem                                            |
// | Purpose : Self-checking bench for reg_bank_mem (2 x 24-bit regs,     |
// |           reg 1 probe, base 0x10): vector table, reset sequences and |
// |           randomized traffic against a behavioural model.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_reg_bank_mem;

  localparam int          BASE = 16'h10;
  localparam int          NR   = 2;
  localparam int          RW   = 24;
  localparam logic [1:0]  RO   = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] addr_i = '0, wdata_i = '0, rdata_i = '0;
  logic        rw_i = 1'b0, valid_i = 1'b0;
  logic [15:0] addr_o, wdata_o, rdata_o;
  logic        rw_o, valid_o, commit_o;
  logic [47:0] probe_i = '0;
  logic [47:0] io_o;

  reg_bank_mem #(
    .BASE_ADDR(BASE), .N_REGS(NR), .REG_WIDTH(RW), .RO_MASK(RO), .IO_INIT(24'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .probe_i(probe_i), .io_o(io_o), .commit_o(commit_o)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: per-register values as plain integers.
  int unsigned m_shadow [NR];
  int unsigned m_snap   [NR];
  int unsigned m_io     [NR];
  int unsigned m_strobe;
  logic [15:0] e_addr, e_wdata, e_rdata;
  logic        e_rw, e_valid, e_commit;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_shadow[r] = 0; m_snap[r] = 0; m_io[r] = 0;
    end
    m_strobe = 0;
    e_addr = 0; e_wdata = 0; e_rdata = 0; e_rw = 0; e_valid = 0; e_commit = 0;
  endtask

  function automatic logic [47:0] model_io();
    logic [47:0] v = '0;
    for (int r = 0; r < NR; r++)
      if (!RO[r]) v = v | (48'(m_io[r]) << (RW * r));
    return v;
  endfunction

  // Apply one clock edge of the address-map rules to the model.
  task automatic model_edge();
    int a, r, w;
    int unsigned val, sh, msk;
    a = int'(addr_i) - BASE;
    e_addr = addr_i; e_wdata = wdata_i; e_rw = rw_i; e_valid = valid_i;
    e_rdata = rdata_i; e_commit = 1'b0;
    if (valid_i && a >= 0 && a <= NR * 2) begin
      r = (a - 1) / 2;
      w = (a - 1) % 2;
      sh = 16 * w;
      if (!rw_i) begin
        if (a == 0) e_rdata = 16'(m_strobe);
        else begin
          val = RO[r] ? m_snap[r] : m_shadow[r];
          e_rdata = 16'(val >> sh);
        end
      end else if (a == 0) begin
        m_strobe = int'(wdata_i) % 4;
        if (wdata_i[1]) begin
          for (int k = 0; k < NR; k++) if (!RO[k]) m_io[k] = m_shadow[k];
          e_commit = 1'b1;
        end
        if (wdata_i[0])
          for (int k = 0; k < NR; k++) if (RO[k]) m_snap[k] = int'((probe_i >> (RW * k)) & 48'hFFFFFF);
      end else if (!RO[r]) begin
        msk = 32'hFFFF << sh;
        m_shadow[r] = ((m_shadow[r] & ~msk) | (int'(wdata_i) << sh)) & 32'hFFFFFF;
      end
    end
  endtask

  // One bus cycle: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic step(input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd,
                      input logic r, input logic v, input logic [47:0] p);
    @(negedge clk);
    addr_i = a; wdata_i = wd; rdata_i = rd; rw_i = r; valid_i = v; probe_i = p;
    @(posedge clk);
    model_edge();
    #1;
    check("bus", {14'd0, addr_o, wdata_o, rdata_o, rw_o, valid_o},
                 {14'd0, e_addr, e_wdata, e_rdata, e_rw, e_valid});
    check("io", {16'd0, io_o}, {16'd0, model_io()});
    check("commit", {63'd0, commit_o}, {63'd0, e_commit});
  endtask

  // Assert reset between edges and verify every output clears at once.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(name, {addr_o, wdata_o, rdata_o, rw_o, valid_o, commit_o, 13'd0},
                {16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 13'd0});
    check({name, "_io"}, {16'd0, io_o}, 64'd0);
    model_reset();
    addr_i = 0; wdata_i = 0; rdata_i = 0; rw_i = 0; valid_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr, wdata, rdata;
    logic        rw, valid;
    logic [47:0] probe;
    logic [15:0] exp_rd;
    logic [47:0] exp_io;
    logic        exp_c;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd,
                              input logic r, input logic [47:0] p, input logic [15:0] er,
                              input logic [47:0] eio, input logic ec);
    vec_t t;
    t.addr = a; t.wdata = wd; t.rdata = rd; t.rw = r; t.valid = 1'b1; t.probe = p;
    t.exp_rd = er; t.exp_io = eio; t.exp_c = ec;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [63:0] rnd;
    logic [15:0] ra;
    tbl.push_back(mk(16'h11, 16'h0000, 16'h5555, 0, 48'h0, 16'h0000, 48'h0, 0));
    tbl.push_back(mk(16'h20, 16'h0000, 16'hBEEF, 0, 48'h0, 16'hBEEF, 48'h0, 0));
    tbl.push_back(mk(16'h11, 16'hCAFE, 16'h0000, 1, 48'h0, 16'h0000, 48'h0, 0));
    tbl.push_back(mk(16'h12, 16'h12AB, 16'h0000, 1, 48'h0, 16'h0000, 48'h0, 0));
    tbl.push_back(mk(16'h12, 16'h0000, 16'h0000, 0, 48'h0, 16'h00AB, 48'h0, 0));
    tbl.push_back(mk(16'h11, 16'h0000, 16'h0000, 0, 48'h0, 16'hCAFE, 48'h0, 0));
    tbl.push_back(mk(16'h10, 16'h0002, 16'h0000, 1, 48'h0, 16'h0000, 48'h0000_00AB_CAFE, 1));
    tbl.push_back(mk(16'h10, 16'h0000, 16'h0000, 0, 48'h0, 16'h0002, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h10, 16'h0001, 16'h0000, 1, 48'h123456_000000, 16'h0000, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h13, 16'h0000, 16'h0000, 0, 48'h0, 16'h3456, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h14, 16'h0000, 16'h0000, 0, 48'h0, 16'h0012, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h13, 16'hFFFF, 16'h0000, 1, 48'h0, 16'h0000, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h13, 16'h0000, 16'h0000, 0, 48'h0, 16'h3456, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h0F, 16'h0000, 16'h1234, 0, 48'h0, 16'h1234, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h15, 16'h0000, 16'h4321, 0, 48'h0, 16'h4321, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h15, 16'hFFFF, 16'h0000, 1, 48'h0, 16'h0000, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h0F, 16'hFFFF, 16'h0000, 1, 48'h0, 16'h0000, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h11, 16'h0000, 16'h0000, 0, 48'h0, 16'hCAFE, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h12, 16'hFF77, 16'h0000, 1, 48'h0, 16'h0000, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h12, 16'h0000, 16'h0000, 0, 48'h0, 16'h0077, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h11, 16'h0001, 16'h0000, 1, 48'h0, 16'h0000, 48'h0000_00AB_CAFE, 0));
    tbl.push_back(mk(16'h10, 16'h0003, 16'h0000, 1, 48'hAAAAAA_000000, 16'h0000, 48'h0000_0077_0001, 1));
    tbl.push_back(mk(16'h13, 16'h0000, 16'h0000, 0, 48'h0, 16'hAAAA, 48'h0000_0077_0001, 0));
    tbl.push_back(mk(16'h10, 16'h0000, 16'h0000, 0, 48'h0, 16'h0003, 48'h0000_0077_0001, 0));

    model_reset();
    repeat (2) @(posedge clk);
    do_reset("reset");

    foreach (tbl[k]) begin
      step(tbl[k].addr, tbl[k].wdata, tbl[k].rdata, tbl[k].rw, tbl[k].valid, tbl[k].probe);
      check($sformatf("tbl%0d_rdata", k), {48'd0, rdata_o}, {48'd0, tbl[k].exp_rd});
      check($sformatf("tbl%0d_io", k), {16'd0, io_o}, {16'd0, tbl[k].exp_io});
      check($sformatf("tbl%0d_commit", k), {63'd0, commit_o}, {63'd0, tbl[k].exp_c});
    end

    // Commit pulse lasts exactly one cycle.
    step(16'h0, 16'h0, 16'h0, 0, 0, 48'h0);
    check("commit_drop", {63'd0, commit_o}, 64'd0);

    // Reset with a half-written shadow: staged data is discarded.
    step(16'h11, 16'h1111, 16'h0, 1, 1, 48'h0);
    step(16'h12, 16'h0022, 16'h0, 1, 1, 48'h0);
    do_reset("reset_mid");
    step(16'h11, 16'h0, 16'h9999, 0, 1, 48'h0);
    check("rst_shadow_lo", {48'd0, rdata_o}, 64'd0);
    step(16'h10, 16'h0002, 16'h0, 1, 1, 48'h0);
    check("rst_commit_io", {16'd0, io_o}, 64'd0);
    check("rst_commit_pulse", {63'd0, commit_o}, 64'd1);

    // Randomized traffic around and inside the window.
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom, $urandom};
      ra  = 16'(16'h0E + $urandom_range(0, 8));
      if ($urandom_range(0, 19) == 0) ra = 16'($urandom);
      step(ra, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), rnd[47:0]);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
